// File: rtl/sdr_tune_ctrl.sv
// sdr_tune_ctrl: UART byte-command sequencer driving NCO phase increment and CIC gain.
// Optional '?' readback of phase_inc is built when SDR_TUNE_READBACK_EN is defined.
module sdr_tune_ctrl #(
    parameter logic [63:0] PRESET_A     = 64'h04CF41F212D77318,
    parameter logic [63:0] PRESET_B     = 64'h01AA60F8B8911654,
    parameter logic [63:0] STEP_9K      = 64'h00071B375868D170,
    parameter logic [63:0] STEP_1K      = 64'h0000CA22980BA57E,
    parameter logic [63:0] STEP_100     = 64'h00001436A8CDF6F3,
    parameter logic [63:0] MAX_INC      = 64'h2000000000000000,
    parameter int unsigned TIMEOUT_CLKS = 8000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    output logic [63:0] phase_inc,
    output logic        tune_stb,
    output logic [1:0]  cic_gain,
    output logic        busy
);

    localparam int unsigned TW     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_F    = 8'h46;
    localparam logic [7:0] CH_Q    = 8'h3F;

`ifdef SDR_TUNE_READBACK_EN
    typedef enum logic [1:0] {IDLE, HEX, RESP, RDBK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEX, RESP} state_t;
`endif

    state_t          state;
    logic [59:0]     shreg;
    logic [3:0]      digits;
    logic [TW-1:0]   timer;
`ifdef SDR_TUNE_READBACK_EN
    logic [63:0]     snap;
`endif

    logic            cmd_load;
    logic [63:0]     cmd_inc;
    logic [63:0]     hex_full;
    logic [63:0]     hex_clamped;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters map via low nibble + 9 for both cases ('A'/'a' low nibble is 1).
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    function automatic logic [63:0] step_up(input logic [63:0] cur, input logic [63:0] stp);
        logic [64:0] s;
        s = {1'b0, cur} + {1'b0, stp};
        return (s > {1'b0, MAX_INC}) ? MAX_INC : s[63:0];
    endfunction

    function automatic logic [63:0] step_dn(input logic [63:0] cur, input logic [63:0] stp);
        logic [64:0] d;
        d = {1'b0, cur} - {1'b0, stp};
        return d[64] ? 64'h0 : d[63:0];
    endfunction

    // Single-byte commands that load a new phase increment.
    always_comb begin
        cmd_load = 1'b1;
        cmd_inc  = phase_inc;
        case (rx_byte)
            8'h61:   cmd_inc = PRESET_A;
            8'h62:   cmd_inc = PRESET_B;
            8'h6D:   cmd_inc = step_up(phase_inc, STEP_9K);
            8'h6E:   cmd_inc = step_dn(phase_inc, STEP_9K);
            8'h72:   cmd_inc = step_up(phase_inc, STEP_1K);
            8'h71:   cmd_inc = step_dn(phase_inc, STEP_1K);
            8'h70:   cmd_inc = step_up(phase_inc, STEP_100);
            8'h6F:   cmd_inc = step_dn(phase_inc, STEP_100);
            default: cmd_load = 1'b0;
        endcase
    end

    always_comb begin
        hex_full    = {shreg, hex_val(rx_byte)};
        hex_clamped = (hex_full > MAX_INC) ? MAX_INC : hex_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            digits    <= '0;
            timer     <= '0;
            phase_inc <= PRESET_A;
            cic_gain  <= 2'd0;
            tx_byte   <= 8'h00;
            tx_start  <= 1'b0;
            tune_stb  <= 1'b0;
            busy      <= 1'b0;
`ifdef SDR_TUNE_READBACK_EN
            snap      <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            tune_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv) begin
                        if (cmd_load) begin
                            phase_inc <= cmd_inc;
                            tune_stb  <= (cmd_inc != phase_inc);
                            tx_byte   <= CH_K;
                            state     <= RESP;
                            busy      <= 1'b1;
                        end else if (rx_byte[7:2] == 6'b001100) begin
                            cic_gain <= rx_byte[1:0];
                            tx_byte  <= CH_K;
                            state    <= RESP;
                            busy     <= 1'b1;
                        end else if (rx_byte == CH_F) begin
                            shreg  <= '0;
                            digits <= '0;
                            timer  <= '0;
                            state  <= HEX;
                            busy   <= 1'b1;
`ifdef SDR_TUNE_READBACK_EN
                        end else if (rx_byte == CH_Q) begin
                            snap   <= phase_inc;
                            digits <= '0;
                            state  <= RDBK;
                            busy   <= 1'b1;
`endif
                        end else begin
                            tx_byte <= CH_E;
                            state   <= RESP;
                            busy    <= 1'b1;
                        end
                    end
                end
                HEX: begin
                    if (rx_dv) begin
                        timer <= '0;
                        if (!is_hex(rx_byte)) begin
                            tx_byte <= CH_E;
                            state   <= RESP;
                        end else if (digits == 4'hF) begin
                            phase_inc <= hex_clamped;
                            tune_stb  <= (hex_clamped != phase_inc);
                            tx_byte   <= CH_K;
                            state     <= RESP;
                        end else begin
                            shreg  <= hex_full[59:0];
                            digits <= digits + 4'd1;
                        end
                    end else if (timer == T_LAST) begin
                        tx_byte <= CH_E;
                        state   <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                // Skipping a cycle after each strobe gives the UART time to raise tx_busy.
                RESP: begin
                    if (!tx_busy && !tx_start) begin
                        tx_start <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
`ifdef SDR_TUNE_READBACK_EN
                RDBK: begin
                    if (!tx_busy && !tx_start) begin
                        tx_start <= 1'b1;
                        tx_byte  <= hex_char(snap[63:60]);
                        snap     <= {snap[59:0], 4'h0};
                        digits   <= digits + 4'd1;
                        if (digits == 4'hF) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Directed self-checking bench for sdr_tune_ctrl with a short hex timeout.
module tb_sdr_tune_ctrl;

    localparam int unsigned TMO     = 200;
    localparam logic [63:0] P_A     = 64'h04CF41F212D77318;
    localparam logic [63:0] P_B     = 64'h01AA60F8B8911654;
    localparam logic [63:0] P_MAX   = 64'h2000000000000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        hold_busy = 1'b0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic [63:0] phase_inc;
    logic        tune_stb;
    logic [1:0]  cic_gain;
    logic        busy;

    int uart_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;
    int tx_count = 0;
    int start_while_busy = 0;
    logic [7:0] txq[$];

    assign tx_busy = hold_busy | (uart_cnt != 0);

    always #5 clk = ~clk;

    sdr_tune_ctrl #(.TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
        .phase_inc(phase_inc), .tune_stb(tune_stb), .cic_gain(cic_gain), .busy(busy)
    );

    // UART model: captures each strobed byte and stays busy for a few cycles.
    always @(negedge clk) begin
        if (tx_start) begin
            if (tx_busy) start_while_busy++;
            txq.push_back(tx_byte);
            tx_count++;
            uart_cnt = 4;
        end
        if (uart_cnt != 0) uart_cnt = uart_cnt - 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (txq.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (txq.size() == 0) check({tag, "_timeout"}, 64'(txq.size()), 64'd1);
        else check(tag, 64'(txq.pop_front()), 64'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    // Sends one byte, checks the registered result next cycle, then the reply.
    task automatic cmd(input string tag, input logic [7:0] b, input logic [63:0] exp_inc,
                       input logic exp_stb, input logic [7:0] exp_resp);
        send(b);
        check({tag, "_inc"}, phase_inc, exp_inc);
        check({tag, "_stb"}, 64'(tune_stb), 64'(exp_stb));
        @(negedge clk);
        check({tag, "_stb_off"}, 64'(tune_stb), 64'd0);
        wait_tx({tag, "_resp"}, exp_resp);
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        int start;
        string rb;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_inc", phase_inc, P_A);
        check("rst_gain", 64'(cic_gain), 64'd0);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'd0);
        check("rst_stb", 64'(tune_stb), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        cmd("preset_b", "b", P_B, 1'b1, "K");
        cmd("preset_a", "a", P_A, 1'b1, "K");
        cmd("preset_same", "a", P_A, 1'b0, "K");
        cmd("step_9k_up", "m", 64'h04D65D296B404488, 1'b1, "K");
        cmd("step_9k_dn", "n", P_A, 1'b1, "K");

        send("F");
        check("hex_busy", 64'(busy), 64'd1);
        send_str("000000000001000");
        check("hex_no_resp", 64'(txq.size()), 64'd0);
        cmd("hex_10000", "0", 64'h10000, 1'b1, "K");
        send("F");
        send_str("FFFFFFFFFFFFFFF");
        cmd("hex_clamp", "F", P_MAX, 1'b1, "K");
        cmd("inc_clamp", "m", P_MAX, 1'b0, "K");

        send("F");
        send_str("12");
        cmd("hex_bad", "G", P_MAX, 1'b0, "E");

        send("F");
        send_str("123");
        repeat (TMO / 2) @(negedge clk);
        check("tmo_wait_busy", 64'(busy), 64'd1);
        check("tmo_wait_quiet", 64'(txq.size()), 64'd0);
        wait_tx("tmo_resp", "E");
        wait_idle("tmo_idle");
        check("tmo_inc", phase_inc, P_MAX);

        send("F");
        send_str("00000000abcdef0");
        cmd("hex_lower", "1", 64'hABCDEF01, 1'b1, "K");
        cmd("step_100_up", "p", 64'h00001437549BE5F4, 1'b1, "K");

        send("F");
        send_str("000000000000001");
        cmd("hex_10", "0", 64'h10, 1'b1, "K");
        cmd("dec_clamp", "q", 64'h0, 1'b1, "K");
        cmd("dec_zero", "q", 64'h0, 1'b0, "K");
        cmd("gain2", "2", 64'h0, 1'b0, "K");
        check("gain2_val", 64'(cic_gain), 64'd2);
        cmd("unknown", "z", 64'h0, 1'b0, "E");
        check("unknown_gain", 64'(cic_gain), 64'd2);

        send("F");
        send_str("12");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_inc", phase_inc, P_A);
        check("midrst_gain", 64'(cic_gain), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_resp", 64'(txq.size()), 64'd0);

`ifdef SDR_TUNE_READBACK_EN
        send("?");
        check("rdbk_busy", 64'(busy), 64'd1);
        rb = "04CF41F212D77318";
        for (int i = 0; i < 16; i++) begin
            wait_tx($sformatf("rdbk_%0d", i), rb[i]);
            if (i == 0) send("b");
        end
        wait_idle("rdbk_idle");
        repeat (20) @(negedge clk);
        check("rdbk_no_k", 64'(txq.size()), 64'd0);
        check("rdbk_inc", phase_inc, P_A);
`else
        rb = "";
        cmd("qmark", "?", P_A, 1'b0, "E");
`endif

        hold_busy = 1'b1;
        start = tx_count;
        send("b");
        check("hold_inc", phase_inc, P_B);
        check("hold_stb", 64'(tune_stb), 64'd1);
        send("a");
        repeat (1000) @(negedge clk);
        check("hold_no_start", 64'(tx_count - start), 64'd0);
        check("hold_busy", 64'(busy), 64'd1);
        check("hold_drop", phase_inc, P_B);
        hold_busy = 1'b0;
        wait_tx("hold_resp", "K");
        wait_idle("hold_idle");
        repeat (10) @(negedge clk);
        check("hold_one_start", 64'(tx_count - start), 64'd1);

        check("start_while_busy", 64'(start_while_busy), 64'd0);
        check("txq_empty", 64'(txq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
